// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath types for the pipeline controller
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic imem_ren;
    } pctrl_ctrl_t;

    localparam pctrl_ctrl_t PCTRL_ALL_OFF = '0;

    function automatic pctrl_ctrl_t pctrl_ctrl(input logic [4:0] en, input logic [1:0] fl,
                                               input logic ren);
        pctrl_ctrl_t c;
        {c.pc_en, c.ifid_en, c.idex_en, c.exmem_en, c.memwb_en} = en;
        {c.ifid_flush, c.idex_flush} = fl;
        c.imem_ren = ren;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - bundle of pipeline controller signals
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
) (
    input logic CLK
);
    logic             RST;
    logic             hazard;
    logic             ihit;
    logic             dhit;
    logic             exmem_memop;
    logic             branch_taken;
    logic             memwb_halt;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             imemREN;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport pc (
        input  CLK, RST, hazard, ihit, dhit, exmem_memop, branch_taken, memwb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        output imemREN, halted, mem_timeout, stall_cnt, flush_cnt
    );

    modport tb (
        input  CLK,
        output RST, hazard, ihit, dhit, exmem_memop, branch_taken, memwb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        input  imemREN, halted, mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for the five-stage pipeline
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             hazard,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_memop,
    input  logic             branch_taken,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             imemREN,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    pctrl_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;
    pctrl_ctrl_t       ctrl;
    logic              halt_case;
    logic              freeze;
    logic              redirect;
    logic              load_use;
    logic              fetch_miss;
    logic              stall_inc;
    logic              flush_inc;

    // Priority chain: each case is qualified by the absence of every higher one.
    always_comb begin
        halt_case  = (state == HALTED) || memwb_halt;
        freeze     = !halt_case && exmem_memop && !dhit;
        redirect   = !halt_case && !freeze && branch_taken;
        load_use   = !halt_case && !freeze && !branch_taken && hazard;
        fetch_miss = !halt_case && !freeze && !branch_taken && !hazard && !ihit;
        stall_inc  = freeze || load_use || fetch_miss;
        flush_inc  = redirect;
    end

    always_comb begin
        ctrl = PCTRL_ALL_OFF;
        if (RST) begin
            ctrl = pctrl_ctrl(5'b00000, 2'b11, 1'b0);
        end else if (halt_case || freeze) begin
            ctrl = PCTRL_ALL_OFF;
        end else begin
            if (redirect) begin
                ctrl = pctrl_ctrl(5'b11111, 2'b11, 1'b0);
            end else if (load_use) begin
                ctrl = pctrl_ctrl(5'b00111, 2'b01, 1'b0);
            end else if (fetch_miss) begin
                ctrl = pctrl_ctrl(5'b01111, 2'b10, 1'b0);
            end else begin
                ctrl = pctrl_ctrl(5'b11111, 2'b00, 1'b0);
            end
            // DWAIT only re-opens the fetch port once the data access completes.
            ctrl.imem_ren = (state == RUN) || dhit;
        end
    end

    always_comb begin
        pc_en      = ctrl.pc_en;
        ifid_en    = ctrl.ifid_en;
        idex_en    = ctrl.idex_en;
        exmem_en   = ctrl.exmem_en;
        memwb_en   = ctrl.memwb_en;
        ifid_flush = ctrl.ifid_flush;
        idex_flush = ctrl.idex_flush;
        imemREN    = ctrl.imem_ren;
        halted     = !RST && halt_case;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memwb_halt) begin
                        state <= HALTED;
                    end else if (exmem_memop && !dhit) begin
                        state    <= DWAIT;
                        wait_cnt <= '0;
                    end
                end
                DWAIT: begin
                    if (memwb_halt) begin
                        state <= HALTED;
                    end else if (dhit) begin
                        state <= RUN;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if ((wait_cnt + WAIT_W'(1)) == WAIT_MAX) begin
                            mem_timeout <= 1'b1;
                        end
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .clr   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .clr   (RST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam logic [9:0] NORM  = 10'b11111_00_1_0_0;
    localparam logic [9:0] RSTV  = 10'b00000_11_0_0_0;
    localparam logic [9:0] FRZ   = 10'b00000_00_0_0_0;
    localparam logic [9:0] LU    = 10'b00111_01_1_0_0;
    localparam logic [9:0] REDIR = 10'b11111_11_1_0_0;
    localparam logic [9:0] FMISS = 10'b01111_10_1_0_0;
    localparam logic [9:0] HALT  = 10'b00000_00_0_1_0;
    localparam logic [9:0] TO    = 10'b00000_00_0_0_1;

    typedef struct {
        string      name;
        logic [9:0] ctrl;
        logic [3:0] stall;
        logic [3:0] flush;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(4)) ifc (.CLK(clk));

    pipeline_ctrl #(.CNT_W(4), .TIMEOUT(3)) dut (
        .CLK          (clk),
        .RST          (ifc.RST),
        .hazard       (ifc.hazard),
        .ihit         (ifc.ihit),
        .dhit         (ifc.dhit),
        .exmem_memop  (ifc.exmem_memop),
        .branch_taken (ifc.branch_taken),
        .memwb_halt   (ifc.memwb_halt),
        .pc_en        (ifc.pc_en),
        .ifid_en      (ifc.ifid_en),
        .idex_en      (ifc.idex_en),
        .exmem_en     (ifc.exmem_en),
        .memwb_en     (ifc.memwb_en),
        .ifid_flush   (ifc.ifid_flush),
        .idex_flush   (ifc.idex_flush),
        .imemREN      (ifc.imemREN),
        .halted       (ifc.halted),
        .mem_timeout  (ifc.mem_timeout),
        .stall_cnt    (ifc.stall_cnt),
        .flush_cnt    (ifc.flush_cnt)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step(input string name, input logic rst, input logic hz, input logic ih,
                        input logic dh, input logic mo, input logic br, input logic ht,
                        input logic [9:0] c, input int st, input int fl);
        exp_t e;
        @(posedge clk);
        #1;
        ifc.RST          = rst;
        ifc.hazard       = hz;
        ifc.ihit         = ih;
        ifc.dhit         = dh;
        ifc.exmem_memop  = mo;
        ifc.branch_taken = br;
        ifc.memwb_halt   = ht;
        e.name  = name;
        e.ctrl  = c;
        e.stall = 4'(st);
        e.flush = 4'(fl);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] act;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            act = {ifc.pc_en, ifc.ifid_en, ifc.idex_en, ifc.exmem_en, ifc.memwb_en,
                   ifc.ifid_flush, ifc.idex_flush, ifc.imemREN, ifc.halted, ifc.mem_timeout};
            n_checks++;
            if (act !== e.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
            end
            n_checks++;
            if (ifc.stall_cnt !== e.stall) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, ifc.stall_cnt, e.stall);
            end
            n_checks++;
            if (ifc.flush_cnt !== e.flush) begin
                n_fail++;
                $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, ifc.flush_cnt, e.flush);
            end
        end
    end

    initial begin
        ifc.RST          = 1'b1;
        ifc.hazard       = 1'b0;
        ifc.ihit         = 1'b1;
        ifc.dhit         = 1'b0;
        ifc.exmem_memop  = 1'b1;
        ifc.branch_taken = 1'b0;
        ifc.memwb_halt   = 1'b1;

        //   name            rst hz ih dh mo br ht  ctrl        stall flush
        step("rst_a",        1, 1, 0, 0, 1, 1, 0, RSTV,       0, 0);
        step("rst_b",        1, 0, 1, 1, 0, 0, 1, RSTV,       0, 0);
        step("release",      0, 0, 1, 0, 0, 0, 0, NORM,       0, 0);
        step("miss_1",       0, 0, 1, 0, 1, 0, 0, FRZ,        0, 0);
        step("miss_2",       0, 0, 1, 0, 1, 0, 0, FRZ,        1, 0);
        step("miss_3",       0, 0, 1, 0, 1, 0, 0, FRZ,        2, 0);
        step("miss_4",       0, 0, 1, 0, 1, 0, 0, FRZ,        3, 0);
        step("miss_5",       0, 0, 1, 0, 1, 0, 0, FRZ | TO,   4, 0);
        step("miss_dhit",    0, 0, 1, 1, 1, 0, 0, NORM | TO,  5, 0);
        step("after_miss",   0, 0, 1, 0, 0, 0, 0, NORM | TO,  5, 0);
        step("rst_clear",    1, 0, 1, 0, 0, 0, 0, RSTV | TO,  5, 0);
        step("load_use",     0, 1, 1, 0, 0, 0, 0, LU,         0, 0);
        step("after_lu",     0, 0, 1, 0, 0, 0, 0, NORM,       1, 0);
        step("redirect",     0, 1, 0, 0, 0, 1, 0, REDIR,      1, 0);
        step("after_redir",  0, 0, 1, 0, 0, 0, 0, NORM,       1, 1);
        step("fetch_miss",   0, 0, 0, 0, 0, 0, 0, FMISS,      1, 1);
        step("after_fmiss",  0, 0, 1, 0, 0, 0, 0, NORM,       2, 1);
        step("br_in_freeze", 0, 0, 1, 0, 1, 1, 0, FRZ,        2, 1);
        step("br_release",   0, 0, 1, 1, 1, 1, 0, REDIR,      3, 1);
        step("after_br",     0, 0, 1, 0, 0, 0, 0, NORM,       3, 2);
        step("halt_freeze",  0, 0, 1, 0, 1, 0, 1, HALT,       3, 2);
        step("halted_1",     0, 1, 0, 0, 1, 1, 0, HALT,       3, 2);
        step("halted_2",     0, 0, 1, 1, 0, 0, 0, HALT,       3, 2);
        step("rst_halted",   1, 0, 1, 0, 0, 0, 0, RSTV,       3, 2);
        step("post_rst",     0, 0, 1, 0, 0, 0, 0, NORM,       0, 0);
        for (int k = 1; k <= 20; k++) begin
            step("sat_miss", 0, 0, 1, 0, 1, 0, 0, (k >= 5) ? (FRZ | TO) : FRZ,
                 (k - 1 > 15) ? 15 : k - 1, 0);
        end
        step("sat_dhit",     0, 0, 1, 1, 1, 0, 0, NORM | TO, 15, 0);

        for (int i = 0; i < 4 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline stall/flush controller for the five-stage datapath. It consumes the `hazard` flag from the hazard unit, the cache hit strobes and the branch/halt status, and drives the per-stage latch enable and flush controls. It also gates the instruction-fetch request while a data access owns the memory port. It sits in the datapath top level, between the hazard unit and the IF/ID, ID/EX, EX/MEM and MEM/WB latches.

## Interface
- `CNT_W`, default 16: width of the saturating performance counters.
- `TIMEOUT`, default 255: maximum number of cycles in DWAIT before `mem_timeout` is raised.
- `CLK` in 1: the single clock, rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `hazard` in 1: load-use hazard from the hazard unit.
- `ihit` in 1: instruction cache hit.
- `dhit` in 1: data cache hit.
- `exmem_memop` in 1: the EX/MEM instruction performs `dmemREN` or `dmemWEN`.
- `branch_taken` in 1: the EX stage resolved a taken branch or jump.
- `memwb_halt` in 1: a halt instruction is in MEM/WB.
- `pc_en` out 1: PC load enable.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: latch enables.
- `ifid_flush`, `idex_flush` out 1 each: insert a bubble in the latch on this edge.
- `imemREN` out 1: instruction fetch request.
- `halted` out 1: sticky halt indication.
- `mem_timeout` out 1: sticky DWAIT watchdog flag.
- `stall_cnt` out `CNT_W`: count of frozen or stalled cycles, saturating.
- `flush_cnt` out `CNT_W`: count of branch flushes, saturating.

## Operation
- States: RUN, DWAIT, HALTED.
- Transitions:
  - RUN→DWAIT when `exmem_memop` & !`dhit`.
  - DWAIT→RUN on `dhit`.
  - Any state→HALTED on `memwb_halt`; this has the highest priority.
  - HALTED is left only by `RST`.
- The controls are combinational from the state and inputs. Priority, highest first:
  1. HALTED: all enables 0, flushes 0, `imemREN`=0, `halted`=1.
  2. Memory freeze, when `exmem_memop` & !`dhit` (in RUN or DWAIT): all enables 0, flushes 0, `imemREN`=0.
  3. Redirect, on `branch_taken`: `pc_en`=1 so the PC loads the target, `ifid_flush`=1, `idex_flush`=1, and all other enables 1. Redirect is independent of `ihit`.
  4. Load-use, on `hazard`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=`memwb_en`=1.
  5. Fetch miss, on !`ihit`: `pc_en`=0, `ifid_flush`=1, and the downstream enables are 1.
  6. Normal: all enables 1, flushes 0.
- When a flush and an enable are asserted on the same latch, the flush wins and the latch loads a bubble.
- `imemREN`=1 in RUN with no memory freeze, and also in DWAIT once `dhit` has arrived.
- Counters:
  - `stall_cnt` increments on every cycle in priority cases 2, 4 or 5.
  - `flush_cnt` increments on every cycle in case 3.
  - Both saturate at all-ones and do not count in HALTED.
- Watchdog: a wait counter clears on entry to DWAIT and increments each DWAIT cycle. When it reaches `TIMEOUT`, `mem_timeout` is set and stays set until reset. The FSM stays in DWAIT.

## Timing
- Reset values: state RUN, `halted`=0, `mem_timeout`=0, both counters 0.
- While `RST`=1 the outputs follow RUN decoding with stalls suppressed: all enables 0, flushes 1, `imemREN`=0.
- A reset in the middle of DWAIT or HALTED returns to RUN on the next edge.
- Control outputs have zero latency with respect to their inputs. State, counters and sticky flags update on the rising edge of `CLK`.
- `dhit` in the same cycle as `exmem_memop` gives no freeze and no DWAIT entry.
- `memwb_halt` together with a memory freeze: HALTED is entered on the next edge, and the outputs in the current cycle already follow case 1.
- `branch_taken` during a memory freeze has no effect. The branch stays in EX and is re-evaluated once the freeze releases.
- `hazard` together with `branch_taken`: redirect wins and the load-use instruction is flushed.
- Counter saturation: at all-ones the counter holds its value and does not wrap.

## Structure
- The `pctrl_state_t` enum (RUN, DWAIT, HALTED) goes in `cpu_types_pkg`.
- A `pipeline_ctrl_if` interface is added in the same style as the other stage interfaces, with a `pc` modport and a `tb` modport.
- One sub-module, `sat_counter` (parameter `W`, inputs `inc` and `clr`, output `count`), instantiated twice.

## Test plan
- Reset: hold `RST` for 2 cycles with all inputs toggling → enables 0, `imemREN`=0, counters 0. After release with `ihit`=1 → all enables 1.
- Data miss: `exmem_memop`=1 with `dhit`=0 for 5 cycles, then `dhit`=1 → freeze for 5 cycles, state DWAIT, `stall_cnt`=5; on the `dhit` cycle all enables are 1.
- Load-use: `hazard`=1 for 1 cycle with `ihit`=1 → `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `stall_cnt`=1.
- Redirect: `branch_taken`=1, `hazard`=1 and `ihit`=0 together → `pc_en`=1, both flushes 1, `flush_cnt`=1, `stall_cnt` unchanged.
- Halt: `memwb_halt`=1 while `exmem_memop`=1 and `dhit`=0 → `halted`=1 next cycle and stays 1 after `memwb_halt` drops; counters frozen.
- Watchdog and saturation: with `TIMEOUT`=3 and `CNT_W`=4, hold a data miss for 20 cycles → `mem_timeout`=1 after the 3rd DWAIT cycle, `stall_cnt`=15 held.
